// File: rtl/adc_capture_pkg.sv
// Shared constants for the ADC capture packer: FIFO word formatting modes
// and the channel-select width helper.
package adc_capture_pkg;

   typedef enum logic [1:0] {
      MODE_PARALLEL   = 2'd0,
      MODE_INTERLEAVE = 2'd1,
      MODE_COUNTER    = 2'd2,
      MODE_RESERVED   = 2'd3
   } mode_e;

   // A single-channel build still needs a one-bit select port.
   function automatic int ch_sel_width(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

endpackage

// File: rtl/adc_interleaver.sv
// Slot shift-register assembler: packs NUM_CH consecutive samples of one
// channel into a word, earliest sample in the MSB slot.
module adc_interleaver
   import adc_capture_pkg::*;
#(
   parameter int  NUM_CH = 2,
   parameter int  ADC_W  = 10,
   localparam int OUT_W  = NUM_CH * ADC_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [ADC_W-1:0] in_sample,
   output logic             out_valid,
   output logic [OUT_W-1:0] out_word
);

   generate
      if (NUM_CH == 1) begin : g_single
         assign out_valid = in_valid;
         assign out_word  = in_sample;
      end else begin : g_multi
         localparam int SW = ch_sel_width(NUM_CH);
         localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_CH - 1);

         logic [SW-1:0]          slot_q, slot_d;
         logic [OUT_W-ADC_W-1:0] hold_q, hold_d;

         always_comb begin
            slot_d    = slot_q;
            hold_d    = hold_q;
            out_valid = 1'b0;
            out_word  = {hold_q, in_sample};
            if (clear) begin
               slot_d = '0;
               hold_d = '0;
            end else if (in_valid) begin
               // Older samples drift toward the MSBs as new ones arrive.
               hold_d = (OUT_W - ADC_W)'({hold_q, in_sample});
               if (slot_q == LAST_SLOT) begin
                  out_valid = 1'b1;
                  slot_d    = '0;
               end else begin
                  slot_d = slot_q + 1'b1;
               end
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               slot_q <= '0;
               hold_q <= '0;
            end else begin
               slot_q <= slot_d;
               hold_q <= hold_d;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/adc_capture_packer.sv
// ADC capture front end: registers the channel buses, decimates, formats
// FIFO words by mode and counts words dropped against a full FIFO.
module adc_capture_packer
   import adc_capture_pkg::*;
#(
   parameter int  NUM_CH = 2,
   parameter int  ADC_W  = 10,
   parameter int  CNT_W  = 16,
   localparam int OUT_W  = NUM_CH * ADC_W,
   localparam int CSW    = ch_sel_width(NUM_CH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [OUT_W-1:0] adc_data,
   input  logic             enable,
   input  logic [1:0]       mode,
   input  logic [CSW-1:0]   ch_sel,
   input  logic [2:0]       decim_log2,
   input  logic             clr_ovf,
   input  logic             fifo_full,
   output logic [OUT_W-1:0] fifo_wdata,
   output logic             fifo_winc,
   output logic [CNT_W-1:0] overflow_cnt,
   output logic             overflow
);

   logic [OUT_W-1:0] s1_q;
   logic [1:0]       mode_q;
   logic [CSW-1:0]   ch_sel_q;
   logic [2:0]       decim_q;
   logic [6:0]       dec_cnt_q, dec_cnt_d;
   logic [OUT_W-1:0] pat_q, pat_d;
   logic             winc_q, winc_d;
   logic [OUT_W-1:0] wdata_q, wdata_d;
   logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
   logic             ovf_q, ovf_d;

   logic             cfg_change, run, accept, produce, drop;
   logic [6:0]       dec_max;
   logic [OUT_W-1:0] word;
   logic [ADC_W-1:0] ch_arr [NUM_CH];
   logic [ADC_W-1:0] sel_sample;
   logic             ilv_valid;
   logic [OUT_W-1:0] ilv_word;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         assign ch_arr[gi] = s1_q[(NUM_CH-gi)*ADC_W-1 -: ADC_W];
      end
   endgenerate

   // Any config edit restarts decimation and slot filling; the edit cycle itself produces nothing.
   assign cfg_change = (mode != mode_q) || (ch_sel != ch_sel_q) || (decim_log2 != decim_q);
   assign run        = enable && !cfg_change && (mode_q != MODE_RESERVED);
   assign dec_max    = 7'((8'd1 << decim_q) - 8'd1);
   assign accept     = run && (dec_cnt_q == '0);
   assign sel_sample = (int'(ch_sel_q) < NUM_CH) ? ch_arr[ch_sel_q] : '0;

   adc_interleaver #(
      .NUM_CH (NUM_CH),
      .ADC_W  (ADC_W)
   ) u_ilv (
      .clk       (clk),
      .rst       (rst),
      .clear     (!run),
      .in_valid  (accept && (mode_q == MODE_INTERLEAVE)),
      .in_sample (sel_sample),
      .out_valid (ilv_valid),
      .out_word  (ilv_word)
   );

   always_comb begin
      produce   = 1'b0;
      word      = s1_q;
      dec_cnt_d = '0;
      if (run) begin
         dec_cnt_d = (dec_cnt_q >= dec_max) ? '0 : dec_cnt_q + 1'b1;
      end
      if (accept) begin
         case (mode_q)
            MODE_PARALLEL: begin
               produce = 1'b1;
               word    = s1_q;
            end
            MODE_INTERLEAVE: begin
               produce = ilv_valid;
               word    = ilv_word;
            end
            MODE_COUNTER: begin
               produce = 1'b1;
               word    = pat_q;
            end
            default: ;
         endcase
      end

      pat_d   = (produce && (mode_q == MODE_COUNTER)) ? pat_q + 1'b1 : pat_q;
      drop    = produce && fifo_full;
      winc_d  = produce && !fifo_full;
      wdata_d = winc_d ? word : wdata_q;

      ovf_cnt_d = ovf_cnt_q;
      ovf_d     = ovf_q;
      // A drop coinciding with a clear leaves a count of one.
      if (drop) begin
         ovf_d = 1'b1;
         if (clr_ovf) begin
            ovf_cnt_d = CNT_W'(1);
         end else if (ovf_cnt_q != '1) begin
            ovf_cnt_d = ovf_cnt_q + 1'b1;
         end
      end else if (clr_ovf) begin
         ovf_cnt_d = '0;
         ovf_d     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q      <= '0;
         mode_q    <= '0;
         ch_sel_q  <= '0;
         decim_q   <= '0;
         dec_cnt_q <= '0;
         pat_q     <= '0;
         winc_q    <= 1'b0;
         wdata_q   <= '0;
         ovf_cnt_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         s1_q      <= adc_data;
         mode_q    <= mode;
         ch_sel_q  <= ch_sel;
         decim_q   <= decim_log2;
         dec_cnt_q <= dec_cnt_d;
         pat_q     <= pat_d;
         winc_q    <= winc_d;
         wdata_q   <= wdata_d;
         ovf_cnt_q <= ovf_cnt_d;
         ovf_q     <= ovf_d;
      end
   end

   assign fifo_wdata   = wdata_q;
   assign fifo_winc    = winc_q;
   assign overflow_cnt = ovf_cnt_q;
   assign overflow     = ovf_q;

endmodule
